// File: rtl/r2mdc_delay_commutator_if.sv
// Sample-pair stream between R2MDC pipeline stages: one valid strobe and two
// complex lanes (lane 0 = butterfly upper path, lane 1 = lower path).
interface r2mdc_delay_commutator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid;
    logic [WIDTH-1:0] lane0_re;
    logic [WIDTH-1:0] lane0_im;
    logic [WIDTH-1:0] lane1_re;
    logic [WIDTH-1:0] lane1_im;

    modport master (output valid, lane0_re, lane0_im, lane1_re, lane1_im);
    modport slave  (input  valid, lane0_re, lane0_im, lane1_re, lane1_im);
endinterface

// File: rtl/r2mdc_delay_commutator.sv
// R2MDC inter-stage reorder: delays lane 1, commutates lanes every DELAY samples,
// then delays the upper lane so the next butterfly sees correctly paired operands.
module r2mdc_delay_commutator #(
    parameter int unsigned DELAY = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    r2mdc_delay_commutator_if.slave         in_if,
    r2mdc_delay_commutator_if.master        out_if,
    output logic                            pattern
);
    localparam int unsigned CntW   = $clog2(DELAY) + 1;
    localparam int unsigned PrimeW = $clog2(DELAY + 1);
    localparam logic [PrimeW-1:0] PrimeFull = PrimeW'(DELAY);

    typedef logic [2*WIDTH-1:0] sample_t;

    sample_t           lane1_dly_q [DELAY];
    sample_t           upper_dly_q [DELAY];
    logic [CntW-1:0]   phase_q, phase_d;
    logic [PrimeW-1:0] prime_q, prime_d;
    logic              out_valid_q;
    sample_t           out0_q, out1_q;

    sample_t a_in, b_in, d_tap, u_sw, l_sw;

    always_comb begin
        a_in    = {in_if.lane0_re, in_if.lane0_im};
        b_in    = {in_if.lane1_re, in_if.lane1_im};
        d_tap   = lane1_dly_q[DELAY-1];
        u_sw    = phase_q[CntW-1] ? d_tap : a_in;
        l_sw    = phase_q[CntW-1] ? a_in  : d_tap;
        // Counter width makes the natural wrap exactly 2*DELAY.
        phase_d = phase_q + CntW'(1);
        prime_d = (prime_q == PrimeFull) ? prime_q : prime_q + PrimeW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                lane1_dly_q[i] <= '0;
                upper_dly_q[i] <= '0;
            end
            phase_q     <= '0;
            prime_q     <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                lane1_dly_q[i] <= '0;
                upper_dly_q[i] <= '0;
            end
            phase_q     <= '0;
            prime_q     <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else if (in_if.valid) begin
            lane1_dly_q[0] <= b_in;
            upper_dly_q[0] <= u_sw;
            for (int i = 1; i < int'(DELAY); i++) begin
                lane1_dly_q[i] <= lane1_dly_q[i-1];
                upper_dly_q[i] <= upper_dly_q[i-1];
            end
            out0_q      <= upper_dly_q[DELAY-1];
            out1_q      <= l_sw;
            phase_q     <= phase_d;
            prime_q     <= prime_d;
            // Valid only once DELAY samples were already accepted before this one.
            out_valid_q <= (prime_q == PrimeFull);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_if.valid    = out_valid_q;
    assign out_if.lane0_re = out0_q[2*WIDTH-1:WIDTH];
    assign out_if.lane0_im = out0_q[WIDTH-1:0];
    assign out_if.lane1_re = out1_q[2*WIDTH-1:WIDTH];
    assign out_if.lane1_im = out1_q[WIDTH-1:0];
    assign pattern         = phase_q[CntW-1];
endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// Bench for r2mdc_delay_commutator: DELAY=1,2,4 instances share one input stream
// and are compared each cycle against a sample-history model.
module tb_r2mdc_delay_commutator;
    localparam int unsigned W  = 16;
    localparam int          NK = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    r2mdc_delay_commutator_if #(.WIDTH(W)) in_if ();
    r2mdc_delay_commutator_if #(.WIDTH(W)) o1_if ();
    r2mdc_delay_commutator_if #(.WIDTH(W)) o2_if ();
    r2mdc_delay_commutator_if #(.WIDTH(W)) o4_if ();
    logic pat1, pat2, pat4;

    r2mdc_delay_commutator #(.DELAY(1), .WIDTH(W)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(in_if), .out_if(o1_if), .pattern(pat1));
    r2mdc_delay_commutator #(.DELAY(2), .WIDTH(W)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(in_if), .out_if(o2_if), .pattern(pat2));
    r2mdc_delay_commutator #(.DELAY(4), .WIDTH(W)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(in_if), .out_if(o4_if), .pattern(pat4));

    logic        o_v [NK];
    logic [31:0] o_0 [NK];
    logic [31:0] o_1 [NK];
    logic        o_p [NK];
    assign o_v[0] = o1_if.valid;
    assign o_v[1] = o2_if.valid;
    assign o_v[2] = o4_if.valid;
    assign o_0[0] = {o1_if.lane0_re, o1_if.lane0_im};
    assign o_0[1] = {o2_if.lane0_re, o2_if.lane0_im};
    assign o_0[2] = {o4_if.lane0_re, o4_if.lane0_im};
    assign o_1[0] = {o1_if.lane1_re, o1_if.lane1_im};
    assign o_1[1] = {o2_if.lane1_re, o2_if.lane1_im};
    assign o_1[2] = {o4_if.lane1_re, o4_if.lane1_im};
    assign o_p[0] = pat1;
    assign o_p[1] = pat2;
    assign o_p[2] = pat4;

    int dl_of [NK] = '{1, 2, 4};

    // Accepted-sample history since last reset/clear; outputs derive from it directly.
    logic [31:0] a_h [4096];
    logic [31:0] b_h [4096];
    int          n_acc = 0;
    logic        e_v [NK];
    logic [31:0] e_0 [NK];
    logic [31:0] e_1 [NK];
    logic        e_p [NK];
    logic        p_seen [NK];

    int checks = 0;
    int errors = 0;

    logic        rec = 1'b0;
    logic [31:0] q1_0 [$];
    logic [31:0] q1_1 [$];
    logic [31:0] q4_0 [$];
    logic [31:0] q4_1 [$];
    logic        qp4 [$];

    function automatic logic [31:0] b_at(input int i);
        return (i >= 0) ? b_h[i] : 32'd0;
    endfunction

    // Upper switch output for sample n: a_n in even DELAY-groups, delayed b in odd ones.
    function automatic logic [31:0] u_at(input int n, input int d);
        if (n < 0) return 32'd0;
        return (((n / d) % 2) == 1) ? b_at(n - d) : a_h[n];
    endfunction

    function automatic logic [31:0] l_at(input int n, input int d);
        return (((n / d) % 2) == 1) ? a_h[n] : b_at(n - d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_acc = 0;
        for (int k = 0; k < NK; k++) begin
            e_v[k] = 1'b0;
            e_0[k] = '0;
            e_1[k] = '0;
            e_p[k] = 1'b0;
        end
    endtask

    task automatic cmp_all(input string tag);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("%s d%0d out_valid", tag, dl_of[k]), 32'(o_v[k]), 32'(e_v[k]));
            chk($sformatf("%s d%0d out_0", tag, dl_of[k]), o_0[k], e_0[k]);
            chk($sformatf("%s d%0d out_1", tag, dl_of[k]), o_1[k], e_1[k]);
            chk($sformatf("%s d%0d pattern", tag, dl_of[k]), 32'(o_p[k]), 32'(e_p[k]));
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (clear) begin
                model_reset();
            end else if (in_if.valid) begin
                a_h[n_acc] = {in_if.lane0_re, in_if.lane0_im};
                b_h[n_acc] = {in_if.lane1_re, in_if.lane1_im};
                if (rec) qp4.push_back(p_seen[2]);
                for (int k = 0; k < NK; k++) begin
                    e_v[k] = (n_acc >= dl_of[k]);
                    e_0[k] = u_at(n_acc - dl_of[k], dl_of[k]);
                    e_1[k] = l_at(n_acc, dl_of[k]);
                    e_p[k] = (((n_acc + 1) / dl_of[k]) % 2) == 1;
                end
                n_acc++;
            end else begin
                for (int k = 0; k < NK; k++) e_v[k] = 1'b0;
            end
            #1;
            cmp_all("cycle");
            if (rec && o_v[0]) begin
                q1_0.push_back(o_0[0]);
                q1_1.push_back(o_1[0]);
            end
            if (rec && o_v[2]) begin
                q4_0.push_back(o_0[2]);
                q4_1.push_back(o_1[2]);
            end
            for (int k = 0; k < NK; k++) p_seen[k] = o_p[k];
        end
    end

    task automatic drive(input logic v, input logic c, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi);
        @(negedge clk);
        in_if.valid    = v;
        clear          = c;
        in_if.lane0_re = ar;
        in_if.lane0_im = ai;
        in_if.lane1_re = br;
        in_if.lane1_im = bi;
    endtask

    task automatic send(input int n);
        drive(1'b1, 1'b0, 16'(n), 16'd0, 16'(100 + n), 16'd0);
    endtask

    task automatic gap(input int cycles);
        for (int i = 0; i < cycles; i++)
            drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        in_if.valid = 1'b0;
        clear       = 1'b0;
        #1;
        model_reset();
        cmp_all("reset");
        for (int k = 0; k < NK; k++) p_seen[k] = o_p[k];
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic start_rec();
        q1_0.delete();
        q1_1.delete();
        q4_0.delete();
        q4_1.delete();
        qp4.delete();
        rec = 1'b1;
    endtask

    // Hand-derived reorder results for a_n=(n,0), b_n=(100+n,0).
    task automatic check_literals(input string tag);
        int          e40 [8] = '{0, 1, 2, 3, 100, 101, 102, 103};
        int          e41 [8] = '{4, 5, 6, 7, 104, 105, 106, 107};
        int          e10 [4] = '{0, 100, 2, 102};
        int          e11 [4] = '{1, 101, 3, 103};
        logic [15:0] pbits = 16'b0000111100001111;
        chk({tag, " d4 valid count"}, 32'(q4_0.size()), 32'd12);
        chk({tag, " d1 valid count"}, 32'(q1_0.size()), 32'd15);
        chk({tag, " d4 pattern count"}, 32'(qp4.size()), 32'd16);
        for (int i = 0; i < 8; i++) begin
            if (i < q4_0.size()) begin
                chk($sformatf("%s d4 lit out_0[%0d]", tag, i), q4_0[i], {16'(e40[i]), 16'd0});
                chk($sformatf("%s d4 lit out_1[%0d]", tag, i), q4_1[i], {16'(e41[i]), 16'd0});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < q1_0.size()) begin
                chk($sformatf("%s d1 lit out_0[%0d]", tag, i), q1_0[i], {16'(e10[i]), 16'd0});
                chk($sformatf("%s d1 lit out_1[%0d]", tag, i), q1_1[i], {16'(e11[i]), 16'd0});
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (i < qp4.size())
                chk($sformatf("%s d4 lit pattern[%0d]", tag, i), 32'(qp4[i]), 32'(pbits[15-i]));
        end
    endtask

    initial begin
        in_if.valid    = 1'b0;
        in_if.lane0_re = '0;
        in_if.lane0_im = '0;
        in_if.lane1_re = '0;
        in_if.lane1_im = '0;
        model_reset();
        do_reset();

        // Continuous directed stream.
        start_rec();
        for (int n = 0; n < 16; n++) send(n);
        gap(2);
        rec = 1'b0;
        check_literals("cont");

        // Same data with 3-cycle gaps after n=2 and n=5.
        do_clear();
        gap(1);
        start_rec();
        for (int n = 0; n < 16; n++) begin
            send(n);
            if (n == 2 || n == 5) gap(3);
        end
        gap(2);
        rec = 1'b0;
        check_literals("gaps");

        // Asynchronous reset mid-stream.
        do_clear();
        for (int n = 0; n < 13; n++) send(n);
        do_reset();
        for (int n = 0; n < 8; n++) send(200 + n);

        // Clear together with a valid pair at n=6.
        do_clear();
        for (int n = 0; n < 6; n++) send(n);
        drive(1'b1, 1'b1, 16'h0bad, 16'h0bad, 16'h0bad, 16'h0bad);
        for (int n = 0; n < 8; n++) send(50 + n);

        // Long continuous run across many phase wraps.
        do_clear();
        for (int n = 0; n < 40; n++)
            drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        // Random valid pattern with occasional clears.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/r2mdc_delay_commutator.md
Name: r2mdc_delay_commutator

Overview:
- Inter-stage reorder unit of the radix-2 multipath delay commutator (R2MDC) FFT pipeline.
- Sits between the butterfly outputs of stage k and the butterfly inputs of stage k+1.
- Delays lane 1 by DELAY samples and swaps the lanes every DELAY samples using an internally generated pattern.
- Delays the swapped upper lane by DELAY samples, so the next butterfly receives correctly paired operands.

Parameters:
- DELAY, 4, delay depth in accepted samples; power of two, >= 1 (DELAY=1 is the final stage).
- WIDTH, 16, bit width of each real/imag component.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous stream restart; clears counters and delay contents.
- in_valid  input  1  in_* carry a sample pair this cycle; the pair is accepted.
- in_0_re  input  WIDTH  lane 0 real (butterfly upper output).
- in_0_im  input  WIDTH  lane 0 imag.
- in_1_re  input  WIDTH  lane 1 real (butterfly lower output).
- in_1_im  input  WIDTH  lane 1 imag.
- out_valid  output  1  out_* hold a valid reordered pair this cycle.
- out_0_re  output  WIDTH  lane 0 real to next butterfly.
- out_0_im  output  WIDTH  lane 0 imag.
- out_1_re  output  WIDTH  lane 1 real.
- out_1_im  output  WIDTH  lane 1 imag.
- pattern  output  1  current swap control, exported for debug and twiddle alignment.

Behaviour:
- Sample index n counts accepted pairs from 0 after reset or clear. a_n = (in_0_re, in_0_im), b_n = (in_1_re, in_1_im).
- Storage:
  - Lane-1 input delay line: DELAY entries of 2*WIDTH.
  - Upper-output delay line: DELAY entries of 2*WIDTH.
  - Both shift only on accepted samples; contents hold when in_valid=0.
- Phase counter: log2(DELAY)+1 bits, increments per accepted sample and wraps mod 2*DELAY. pattern = MSB of the counter, so it toggles every DELAY accepted samples. pattern=0 after reset or clear.
- Switch at sample n, with d_n = b_(n-DELAY):
  - pattern=0: u_n = a_n, l_n = d_n.
  - pattern=1: u_n = d_n, l_n = a_n.
- Outputs:
  - out_0 = u_(n-DELAY), out_1 = l_n.
  - Registered; updated at the clock edge that accepts sample n, visible the following cycle (latency 1 clk after acceptance).
- Resulting output order, in groups of DELAY pairs: (a_0..a_(D-1) | a_D..a_(2D-1)), then (b_0..b_(D-1) | b_D..b_(2D-1)), then the next 2D-sample block repeats.
- Priming:
  - A saturating counter (0..DELAY) tracks accepted samples.
  - out_valid=1 in the cycle after accepting sample n only if n >= DELAY. Otherwise out_valid=0.
  - out_valid is a single-cycle pulse per accepted sample. It is 0 in any cycle following a cycle with in_valid=0.
- Gaps: in_valid low for any number of cycles:
  - No state change.
  - out_* hold their last value.
  - out_valid=0.
- Reset (rst_n low, asynchronous, any time including mid-stream):
  - Clears all delay entries, counters, out_* and pattern to 0; out_valid=0.
  - The next accepted sample after release is n=0.
- clear=1 at a clock edge:
  - Same effect as reset, applied synchronously.
  - Has priority over in_valid; a pair presented in the same cycle is discarded.
- No backpressure: the downstream stage always accepts out_*.
- Arithmetic: pure data movement; no width change, no sign handling.

Test Plan:
- DELAY=1, rst_n released, continuous in_valid, a_n=(n,0), b_n=(100+n,0) for n=0..7:
  - out_valid first high in the cycle after n=1 is accepted.
  - out pairs in order: (0,1), (100,101), (2,3), (102,103), ...
  - pattern toggles each sample: 0,1,0,1...
- DELAY=4, continuous, a_n=n, b_n=100+n:
  - First out_valid in the cycle after n=4.
  - out_0 = 0,1,2,3 then 100..103; out_1 = 4..7 then 104..107.
  - pattern = 0000111100001111.
- DELAY=4, same data with in_valid deasserted for 3 cycles after n=2 and after n=5:
  - Output sequence identical to the previous scenario.
  - out_valid=0 and out_* held during each gap.
- DELAY=4, 13 samples, then rst_n pulsed low mid-cycle:
  - out_*, out_valid and pattern are 0 immediately on reset.
  - After release, the next sample is treated as n=0: no out_valid until 4 more samples are accepted.
- DELAY=4, clear=1 together with in_valid=1 at n=6:
  - That pair is dropped; pattern=0.
  - The following pair becomes n=0; priming restarts with 4 samples before out_valid.
- DELAY=2, run 40 continuous samples:
  - Phase counter wraps cleanly mod 4.
  - Every output pair matches the grouping rule across the wraps; no out_valid glitch at a wrap.
